// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// elaboration-time helpers used to size the fractional tick accumulator.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_DATA  = 2'b10,
      ST_STOP  = 2'b11
   } uart_state_e;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   // Eight fractional bits beyond the integer clock/tick ratio keep the mean
   // tick rate error well under a percent.
   function automatic int tick_acc_w(input longint clk_hz, input longint tick_hz);
      return $clog2(clk_hz / tick_hz) + 8;
   endfunction

   function automatic longint tick_inc(input longint clk_hz, input longint tick_hz,
                                       input int acc_w);
      return ((tick_hz << acc_w) + clk_hz / 2) / clk_hz;
   endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Fractional phase accumulator producing a one-clk tick at Baud*Oversampling.
// Held at its increment while disabled so tick phase restarts with each frame.
module uart_rx_tick
   import uart_rx_pkg::*;
#(
   parameter int ClkFrequency = 100000000,
   parameter int Baud         = 9600,
   parameter int Oversampling = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tick
);

   localparam longint TICK_HZ = longint'(Baud) * longint'(Oversampling);
   localparam int     ACC_W   = tick_acc_w(longint'(ClkFrequency), TICK_HZ);
   localparam logic [ACC_W:0] INC =
      (ACC_W+1)'(tick_inc(longint'(ClkFrequency), TICK_HZ, ACC_W));

   logic [ACC_W:0] r_acc;

   // The top bit is the carry; dropping it on every addition makes it a pulse.
   always_ff @(posedge clk) begin
      if (!rst_n || !enable) begin
         r_acc <= INC;
      end else begin
         r_acc <= {1'b0, r_acc[ACC_W-1:0]} + INC;
      end
   end

   assign tick = r_acc[ACC_W];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronized rxd, oversampled mid-bit sampling, one-clk
// data_ready / framing_error pulses, and break hold-off after a bad stop bit.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int ClkFrequency = 100000000,
   parameter int Baud         = 9600,
   parameter int Oversampling = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_ready,
   output logic                 framing_error,
   output logic                 idle
);

   localparam int SC_W = $clog2(Oversampling);
   localparam int BC_W = $clog2(DATA_BITS);
   localparam logic [SC_W-1:0] SC_MID  = SC_W'(Oversampling / 2 - 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(Oversampling - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

   logic                 r_rxd_meta;
   logic                 r_rxd_sync;
   uart_state_e          r_state;
   logic [SC_W-1:0]      r_sample_cnt;
   logic [BC_W-1:0]      r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_data_ready;
   logic                 r_framing_error;
   logic                 r_idle;
   logic                 r_brk;
   logic                 w_tick;
   logic                 w_tick_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rxd_meta <= 1'b1;
         r_rxd_sync <= 1'b1;
      end else begin
         r_rxd_meta <= rxd;
         r_rxd_sync <= r_rxd_meta;
      end
   end

   assign w_tick_en = (r_state != ST_IDLE);

   uart_rx_tick #(
      .ClkFrequency (ClkFrequency),
      .Baud         (Baud),
      .Oversampling (Oversampling)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (w_tick_en),
      .tick   (w_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_sample_cnt    <= '0;
         r_bit_cnt       <= '0;
         r_shift         <= '0;
         r_data          <= '0;
         r_data_ready    <= 1'b0;
         r_framing_error <= 1'b0;
         r_idle          <= 1'b1;
         r_brk           <= 1'b0;
      end else begin
         r_data_ready    <= 1'b0;
         r_framing_error <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (!r_rxd_sync) begin
                  r_state      <= ST_START;
                  r_idle       <= 1'b0;
                  r_sample_cnt <= '0;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  if (r_sample_cnt == SC_MID) begin
                     r_sample_cnt <= '0;
                     if (!r_rxd_sync) begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= '0;
                     end else begin
                        r_state <= ST_IDLE;
                        r_idle  <= 1'b1;
                     end
                  end else begin
                     r_sample_cnt <= r_sample_cnt + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (r_sample_cnt == SC_LAST) begin
                     r_sample_cnt <= '0;
                     r_shift      <= {r_rxd_sync, r_shift[DATA_BITS-1:1]};
                     if (r_bit_cnt == BC_LAST) begin
                        r_state <= ST_STOP;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end else begin
                     r_sample_cnt <= r_sample_cnt + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               // After a low stop bit, wait out the break so it is not taken as a start.
               if (r_brk) begin
                  if (r_rxd_sync) begin
                     r_brk   <= 1'b0;
                     r_state <= ST_IDLE;
                     r_idle  <= 1'b1;
                  end
               end else if (w_tick) begin
                  if (r_sample_cnt == SC_LAST) begin
                     r_sample_cnt <= '0;
                     if (r_rxd_sync) begin
                        r_data       <= r_shift;
                        r_data_ready <= 1'b1;
                        r_state      <= ST_IDLE;
                        r_idle       <= 1'b1;
                     end else begin
                        r_framing_error <= 1'b1;
                        r_brk           <= 1'b1;
                     end
                  end else begin
                     r_sample_cnt <= r_sample_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_idle  <= 1'b1;
            end
         endcase
      end
   end

   assign data          = r_data;
   assign data_ready    = r_data_ready;
   assign framing_error = r_framing_error;
   assign idle          = r_idle;

endmodule
